digit_scan_mux: RTL and testbench
=================================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning the number of display digits (legal range 1..16).
REQ-002 SHALL have parameter DIGIT_W, default 4, meaning the bit width of one digit code.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (minimum 1).
REQ-004 SHALL have parameter BLINK_FRAMES, default 64, meaning full scan frames per blink half-period (minimum 1).
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 SHALL have port load, input, 1 bit: single-cycle strobe that captures data_in.
REQ-009 SHALL have port data_in, input, NUM_DIGITS*DIGIT_W bits: packed digits; digit i occupies bits [i*DIGIT_W +: DIGIT_W], with digit 0 as the least significant (ones) digit.
REQ-010 SHALL have port lz_blank_en, input, 1 bit: enables leading-zero blanking.
REQ-011 SHALL have port blink_mask, input, NUM_DIGITS bits: digits that blink.
REQ-012 SHALL have port digit_sel, output, clog2(NUM_DIGITS) bits (minimum 1): index of the active digit.
REQ-013 SHALL have port anode_n, output, NUM_DIGITS bits: one-hot active-low digit enable.
REQ-014 SHALL have port data_out, output, DIGIT_W bits: code of the active digit.
REQ-015 SHALL have port blank, output, 1 bit: the active digit is blanked; when blank is 1, the corresponding anode_n bit is 1.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse at scan wrap.

Function
REQ-017 SHALL implement a prescaler counting 0..REFRESH_DIV-1 and emitting a tick on its terminal count, then wrapping to 0.
REQ-018 SHALL advance the digit index by one on each tick, wrapping from NUM_DIGITS-1 to 0; with NUM_DIGITS=1, the index stays 0.
REQ-019 SHALL pulse frame_done for exactly one cycle on the tick where the index wraps to 0.
REQ-020 SHALL double-buffer the input: load writes a shadow register and sets a pending flag; the active register takes the shadow contents only on the wrap tick, so the display never tears mid-frame.
REQ-021 SHALL keep only the last load when several loads occur within one frame.
REQ-022 SHALL, when load coincides with the wrap tick, copy that cycle's data_in directly into the active register and clear pending.
REQ-023 SHALL, when lz_blank_en=1, blank digit i (i>0) if digit i and every digit above it in the active register are zero; digit 0 is never blanked by this rule.
REQ-024 SHALL toggle a blink phase every BLINK_FRAMES wraps; while the phase is 1, SHALL blank digits whose blink_mask bit is set.
REQ-025 SHALL register digit_sel, anode_n, data_out and blank, valid one cycle after the index changes; data_out SHALL still carry the digit code while blanked.
REQ-026 SHALL sample lz_blank_en and blink_mask live, with no buffering.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, clear the prescaler, index, shadow, active, pending and blink phase to 0.
REQ-028 SHALL, during reset, drive anode_n all ones, digit_sel=0, data_out=0, blank=1 and frame_done=0.
REQ-029 SHALL drop any pending load when reset is asserted mid-frame; the first digit 0 slot SHALL begin REFRESH_DIV cycles after reset is released.

Structure
REQ-030 SHALL place the default parameter constants and a helper for the index width (clog2 with a minimum of 1) in the shared display package.
REQ-031 SHALL implement the prescaler as sub-module tick_prescaler (parameter DIV; ports clk, rst_n, tick).

Verification (REFRESH_DIV=4, BLINK_FRAMES=2, NUM_DIGITS=8, DIGIT_W=4)
REQ-032 SHALL check: reset, then free-run -> digit_sel steps 0..7 every 4 cycles, anode_n=8'hFE for digit 0, frame_done pulses once every 32 cycles.
REQ-033 SHALL check: load 32'h12345678 mid-frame -> data_out unchanged until the next frame_done, then the digit 0 slot shows 8 and the digit 7 slot shows 1.
REQ-034 SHALL check: load 32'h00000450 with lz_blank_en=1 -> digits 3..7 blank=1, digits 0..2 blank=0 (digit 0 shows 0).
REQ-035 SHALL check: load 32'h0 with lz_blank_en=1 -> only digit 0 is unblanked and shows 0.
REQ-036 SHALL check: blink_mask=8'h01 -> digit 0 is blanked during frames 2-3 and shown during frames 0-1, repeating.
REQ-037 SHALL check: load on the wrap-tick cycle, followed by a second load and then reset mid-frame -> the first value shows immediately; after reset, outputs return to reset values and the second value is never displayed.

Source files
------------

// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed digit display.
package digit_scan_mux_pkg;

  localparam int DEF_NUM_DIGITS   = 8;
  localparam int DEF_DIGIT_W      = 4;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLINK_FRAMES = 64;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_scan_mux_tick_prescaler.sv
// Free-running divider: tick is high for one cycle on the terminal count DIV-1.
module tick_prescaler
  import digit_scan_mux_pkg::*;
#(
  parameter int DIV = DEF_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = idx_width(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner with double-buffered data, leading-zero
// blanking and per-digit blinking.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DIGIT_W      = DEF_DIGIT_W,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       data_in,
  input  logic                                lz_blank_en,
  input  logic [NUM_DIGITS-1:0]               blink_mask,
  output logic [idx_width(NUM_DIGITS)-1:0]    digit_sel,
  output logic [NUM_DIGITS-1:0]               anode_n,
  output logic [DIGIT_W-1:0]                  data_out,
  output logic                                blank,
  output logic                                frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int BW = idx_width(BLINK_FRAMES);
  localparam int DW = NUM_DIGITS * DIGIT_W;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

  logic                  tick;
  logic [IW-1:0]         idx;
  logic                  running;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         active;
  logic                  pending;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic                  wrap_q;
  logic                  frame_start;
  logic                  wrap;
  logic [DIGIT_W-1:0]    digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] one_hot;
  logic                  blank_now;

  tick_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // The first tick after reset starts frame 0 at digit 0 without counting as a wrap.
  assign frame_start = tick && (!running || (idx == LAST_IDX));
  assign wrap        = tick && running && (idx == LAST_IDX);

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[i] = active[i*DIGIT_W +: DIGIT_W];
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digits[i] == '0);
      lz_mask[i] = zero_above && (i != 0);
    end
  end

  assign one_hot   = NUM_DIGITS'(1) << idx;
  assign blank_now = (lz_blank_en && lz_mask[idx]) || (blink_phase && blink_mask[idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      running     <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (load) begin
        shadow <= data_in;
      end
      // A load on the frame boundary bypasses the shadow so it shows at once.
      if (frame_start) begin
        running <= 1'b1;
        pending <= 1'b0;
        if (load) begin
          active <= data_in;
        end else if (pending) begin
          active <= shadow;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
      if (tick && running) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        if (blink_cnt == LAST_BLINK) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // frame_done is delayed once more so it lines up with the digit 0 outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_sel  <= '0;
      anode_n    <= '1;
      data_out   <= '0;
      blank      <= 1'b1;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wrap_q     <= wrap;
      frame_done <= wrap_q;
      if (!running) begin
        digit_sel <= '0;
        anode_n   <= '1;
        data_out  <= '0;
        blank     <= 1'b1;
      end else begin
        digit_sel <= idx;
        anode_n   <= blank_now ? '1 : ~one_hot;
        data_out  <= digits[idx];
        blank     <= blank_now;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with an 8-digit, 4-cycle-slot, 2-frame-blink setup.
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] data_in;
  logic        lz_blank_en;
  logic [7:0]  blink_mask;
  logic [2:0]  digit_sel;
  logic [7:0]  anode_n;
  logic [3:0]  data_out;
  logic        blank;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS   (8),
    .DIGIT_W      (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .lz_blank_en (lz_blank_en),
    .blink_mask  (blink_mask),
    .digit_sel   (digit_sel),
    .anode_n     (anode_n),
    .data_out    (data_out),
    .blank       (blank),
    .frame_done  (frame_done)
  );

  // cyc counts rising edges since reset release; sampling is 1 ns after each edge.
  task automatic run_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic load_at(input int c, input logic [31:0] v);
    run_to(c - 1);
    load    = 1'b1;
    data_in = v;
    run_to(c);
    load    = 1'b0;
  endtask

  task automatic test_reset();
    lz_blank_en = 1'b0;
    blink_mask  = '0;
    rst_n       = 1'b0;
    load        = 1'b0;
    data_in     = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if ({digit_sel, anode_n, data_out, blank, frame_done} !== {3'd0, 8'hFF, 4'h0, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got sel=%0d an=%h d=%h b=%b fd=%b, expected sel=0 an=ff d=0 b=1 fd=0",
               digit_sel, anode_n, data_out, blank, frame_done);
    end
    rst_n = 1'b1;
    cyc   = 0;
    run_to(4);
    tests++;
    if (anode_n !== 8'hFF || blank !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_before_first_slot: got an=%h b=%b, expected an=ff b=1", anode_n, blank);
    end
    run_to(5);
    tests++;
    if (anode_n !== 8'hFE || digit_sel !== 3'd0 || blank !== 1'b0) begin
      fails++;
      $display("[TB] FAIL first_slot: got an=%h sel=%0d b=%b, expected an=fe sel=0 b=0", anode_n, digit_sel, blank);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_an;
    logic       exp_fd;
    int         k;
    reset_dut();
    for (int c = 1; c <= 72; c++) begin
      run_to(c);
      if (c >= 5) begin
        k      = ((c - 5) / 4) % 8;
        exp_an = ~(8'h01 << k);
        tests++;
        if (digit_sel !== 3'(k) || anode_n !== exp_an) begin
          fails++;
          $display("[TB] FAIL scan_step c=%0d: got sel=%0d an=%h, expected sel=%0d an=%h", c, digit_sel, anode_n, k, exp_an);
        end
      end
      exp_fd = (c >= 37) && ((c - 5) % 32 == 0);
      tests++;
      if (frame_done !== exp_fd) begin
        fails++;
        $display("[TB] FAIL frame_done c=%0d: got %b, expected %b", c, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    reset_dut();
    load_at(12, 32'hAAAAAAAA);
    load_at(16, 32'h12345678);
    for (int c = 17; c <= 36; c++) begin
      run_to(c);
      tests++;
      if (data_out !== 4'h0) begin
        fails++;
        $display("[TB] FAIL no_tear c=%0d: got d=%h, expected d=0", c, data_out);
      end
    end
    run_to(37);
    tests++;
    if (frame_done !== 1'b1 || digit_sel !== 3'd0 || data_out !== 4'h8) begin
      fails++;
      $display("[TB] FAIL new_frame_digit0: got fd=%b sel=%0d d=%h, expected fd=1 sel=0 d=8", frame_done, digit_sel, data_out);
    end
    run_to(49);
    tests++;
    if (digit_sel !== 3'd3 || data_out !== 4'h5) begin
      fails++;
      $display("[TB] FAIL new_frame_digit3: got sel=%0d d=%h, expected sel=3 d=5", digit_sel, data_out);
    end
    run_to(65);
    tests++;
    if (digit_sel !== 3'd7 || data_out !== 4'h1) begin
      fails++;
      $display("[TB] FAIL new_frame_digit7: got sel=%0d d=%h, expected sel=7 d=1", digit_sel, data_out);
    end
  endtask

  task automatic test_lz_blank();
    logic [31:0] v;
    logic [3:0]  exp_d;
    logic        exp_b;
    logic [7:0]  exp_an;
    v = 32'h00000450;
    reset_dut();
    lz_blank_en = 1'b1;
    load_at(8, v);
    for (int k = 0; k < 8; k++) begin
      run_to(37 + 4 * k);
      exp_d  = v[k*4 +: 4];
      exp_b  = (k >= 3);
      exp_an = exp_b ? 8'hFF : ~(8'h01 << k);
      tests++;
      if (blank !== exp_b || data_out !== exp_d || anode_n !== exp_an) begin
        fails++;
        $display("[TB] FAIL lz_blank digit%0d: got b=%b d=%h an=%h, expected b=%b d=%h an=%h",
                 k, blank, data_out, anode_n, exp_b, exp_d, exp_an);
      end
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_all_zero();
    logic       exp_b;
    logic [7:0] exp_an;
    reset_dut();
    lz_blank_en = 1'b1;
    load_at(2, 32'h0);
    for (int k = 0; k < 8; k++) begin
      run_to(5 + 4 * k);
      exp_b  = (k != 0);
      exp_an = exp_b ? 8'hFF : 8'hFE;
      tests++;
      if (blank !== exp_b || data_out !== 4'h0 || anode_n !== exp_an) begin
        fails++;
        $display("[TB] FAIL all_zero digit%0d: got b=%b d=%h an=%h, expected b=%b d=0 an=%h",
                 k, blank, data_out, anode_n, exp_b, exp_an);
      end
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_blink();
    logic       exp_b;
    logic [7:0] exp_an;
    reset_dut();
    blink_mask = 8'h01;
    load_at(2, 32'h12345678);
    for (int f = 0; f < 5; f++) begin
      run_to(5 + 32 * f);
      exp_b  = (f == 2) || (f == 3);
      exp_an = exp_b ? 8'hFF : 8'hFE;
      tests++;
      if (blank !== exp_b || anode_n !== exp_an || data_out !== 4'h8) begin
        fails++;
        $display("[TB] FAIL blink frame%0d digit0: got b=%b an=%h d=%h, expected b=%b an=%h d=8",
                 f, blank, anode_n, data_out, exp_b, exp_an);
      end
      run_to(9 + 32 * f);
      tests++;
      if (blank !== 1'b0 || anode_n !== 8'hFD || data_out !== 4'h7) begin
        fails++;
        $display("[TB] FAIL blink frame%0d digit1: got b=%b an=%h d=%h, expected b=0 an=fd d=7",
                 f, blank, anode_n, data_out);
      end
    end
    blink_mask = 8'h00;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    load_at(36, 32'h87654321);
    run_to(37);
    tests++;
    if (frame_done !== 1'b1 || data_out !== 4'h1) begin
      fails++;
      $display("[TB] FAIL wrap_load_immediate: got fd=%b d=%h, expected fd=1 d=1", frame_done, data_out);
    end
    load_at(40, 32'h99999999);
    run_to(41);
    tests++;
    if (digit_sel !== 3'd1 || data_out !== 4'h2) begin
      fails++;
      $display("[TB] FAIL second_load_deferred: got sel=%0d d=%h, expected sel=1 d=2", digit_sel, data_out);
    end
    run_to(50);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if ({digit_sel, anode_n, data_out, blank, frame_done} !== {3'd0, 8'hFF, 4'h0, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL midframe_reset: got sel=%0d an=%h d=%h b=%b fd=%b, expected sel=0 an=ff d=0 b=1 fd=0",
               digit_sel, anode_n, data_out, blank, frame_done);
    end
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 68; c++) begin
      run_to(c);
      tests++;
      if (data_out !== 4'h0) begin
        fails++;
        $display("[TB] FAIL dropped_load c=%0d: got d=%h, expected d=0", c, data_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_mid_frame();
    test_lz_blank();
    test_all_zero();
    test_blink();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule
